// File: rtl/float_to_int_pipe.sv
// rtl/float_to_int_pipe.sv - pipelined IEEE-754 single to signed integer converter
//
// Three register stages (unpack, align/round, sign/saturate) with a valid/ready
// handshake. Every stage stalls together when the output is held.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready follows out_ready combinationally)
//   floatin             single-precision operand
//   round_mode          0 = truncate toward zero, 1 = nearest, ties to even
//   out_valid, out_ready output handshake
//   intout              signed OUT_WIDTH-bit result
//   sat                 result was clamped (overflow or infinity)
//   invalid             operand was NaN
module float_to_int_pipe #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          floatin,
  input  logic                 round_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] intout,
  output logic                 sat,
  output logic                 invalid
);

  // Largest magnitudes representable for positive and negative results.
  localparam logic [32:0] MAX_MAG = (33'd1 << (OUT_WIDTH - 1)) - 33'd1;
  localparam logic [32:0] MIN_MAG = 33'd1 << (OUT_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [9:0] E_LIMIT = 10'(OUT_WIDTH);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: unpack and classify
  logic              v1, sign1, rm1, zero1, inf1, nan1;
  logic signed [9:0] e1;
  logic [23:0]       man1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (advance) begin
      v1    <= in_valid;
      sign1 <= floatin[31];
      rm1   <= round_mode;
      // Denormals are folded into zero: their magnitude is far below 0.5.
      zero1 <= (floatin[30:23] == 8'h00);
      inf1  <= (floatin[30:23] == 8'hff) && (floatin[22:0] == 23'd0);
      nan1  <= (floatin[30:23] == 8'hff) && (floatin[22:0] != 23'd0);
      e1    <= $signed({2'b00, floatin[30:23]}) - 10'sd127;
      man1  <= {1'b1, floatin[22:0]};
    end
  end

  // Stage 2: align, round, detect overflow
  logic [55:0] shifted;
  logic [32:0] int_part;
  logic [32:0] mag_rnd;
  logic        guard, sticky, round_up, in_range, too_big, ovf;

  // Only exponents 0..OUT_WIDTH-1 (at most 31) ever reach the shifter, so
  // the 56-bit window holds the whole value without loss.
  assign in_range = (e1 >= 10'sd0) && (e1 < E_LIMIT);
  assign too_big  = (e1 >= E_LIMIT);
  assign shifted  = {32'd0, man1} << e1[4:0];

  always_comb begin
    int_part = 33'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (in_range) begin
      int_part = shifted[55:23];
      guard    = shifted[22];
      sticky   = |shifted[21:0];
    end else if (e1 == -10'sd1) begin
      // |x| in [0.5, 1): the hidden bit is the guard bit.
      guard  = 1'b1;
      sticky = |man1[22:0];
    end
    round_up = rm1 && guard && (sticky || int_part[0]);
    mag_rnd  = int_part + {32'd0, round_up};
    // Negative results may reach one further than positive ones.
    ovf = inf1 || too_big || (sign1 ? (mag_rnd > MIN_MAG) : (mag_rnd > MAX_MAG));
  end

  logic                 v2, sign2, nan2, ovf2;
  logic [OUT_WIDTH-1:0] mag2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
    end else if (advance) begin
      v2    <= v1;
      sign2 <= sign1;
      nan2  <= nan1;
      ovf2  <= !zero1 && !nan1 && ovf;
      mag2  <= zero1 ? '0 : mag_rnd[OUT_WIDTH-1:0];
    end
  end

  // Stage 3: apply sign, saturate, register outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      intout    <= '0;
      sat       <= 1'b0;
      invalid   <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      // Bubbles leave the previous result on the outputs.
      if (v2) begin
        if (nan2) begin
          intout  <= '0;
          sat     <= 1'b0;
          invalid <= 1'b1;
        end else if (ovf2) begin
          intout  <= sign2 ? MIN_VAL : MAX_VAL;
          sat     <= 1'b1;
          invalid <= 1'b0;
        end else begin
          intout  <= sign2 ? (~mag2 + 1'b1) : mag2;
          sat     <= 1'b0;
          invalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// tb/tb_float_to_int_pipe.sv - randomized scoreboard bench for float_to_int_pipe
module tb_float_to_int_pipe;

  typedef struct packed {
    logic        inv;
    logic        sat;
    logic [31:0] val;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        a_in_valid = 1'b0, a_in_ready, a_rm = 1'b0, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_f = '0;
  logic [15:0] a_intout;
  logic        a_sat, a_inv;
  // 8-bit instance
  logic        b_in_valid = 1'b0, b_in_ready, b_rm = 1'b0, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_f = '0;
  logic [7:0]  b_intout;
  logic        b_sat, b_inv;

  float_to_int_pipe #(.OUT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .floatin(a_f), .round_mode(a_rm), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .intout(a_intout), .sat(a_sat), .invalid(a_inv));

  float_to_int_pipe #(.OUT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .floatin(b_f), .round_mode(b_rm), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .intout(b_intout), .sat(b_sat), .invalid(b_inv));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_lat = 1'b0;
  int a_outs = 0, b_outs = 0;
  ent_t aq[$];
  ent_t bq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  // Reference: exact value x = mant * 2^(e-23), rounded, signed, clamped.
  function automatic res_t model(input logic [31:0] f, input logic rm, input int w);
    res_t r;
    longint maxv, minv, m, mag, rem, half, v;
    int e, sh;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -maxv - 1;
    r = '0;
    if (f[30:23] == 8'hff) begin
      if (f[22:0] != 23'd0) r.inv = 1'b1;
      else begin
        r.sat = 1'b1;
        v = f[31] ? minv : maxv;
        r.val = v[31:0];
      end
      return r;
    end
    if (f[30:23] == 8'h00) return r;
    e = int'(f[30:23]) - 127;
    m = longint'({1'b1, f[22:0]});
    if (e > 40) mag = longint'(1) << 45;
    else if (e >= 23) mag = m << (e - 23);
    else if (e < -1) mag = 0;
    else begin
      sh = 23 - e;
      mag = m >> sh;
      rem = m - (mag << sh);
      half = longint'(1) << (sh - 1);
      if (rm && (rem > half || (rem == half && mag[0]))) mag++;
    end
    v = f[31] ? -mag : mag;
    if (v > maxv) begin v = maxv; r.sat = 1'b1; end
    else if (v < minv) begin v = minv; r.sat = 1'b1; end
    r.val = v[31:0];
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    case ($urandom % 8)
      0: ;
      1: case ($urandom % 4)
           0: f = {f[31], 8'hff, 23'd0};
           1: f = {f[31], 8'hff, f[22:0] | 23'd1};
           2: f = {f[31], 8'h00, 23'd0};
           default: f = {f[31], 8'h00, f[22:0]};
         endcase
      default: begin
        f[30:23] = 8'(120 + ($urandom % 41));
        if ($urandom % 2) f[22:0] = f[22:0] & 23'h7f0000;
      end
    endcase
    return f;
  endfunction

  // Monitors: scoreboard, stall stability and latency
  logic        a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  logic [17:0] a_hold, b_hold_unused;
  logic [9:0]  b_hold;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      aq.delete();
      bq.delete();
      a_prev_stall = 1'b0;
      b_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall)
        check("a_stall_hold", {a_out_valid, a_inv, a_sat, a_intout}, {1'b1, a_hold});
      if (a_out_valid && !a_out_ready) check("a_stall_in_ready", a_in_ready, 0);
      if (a_out_valid && a_out_ready) begin
        a_outs++;
        if (aq.size() == 0) fail("a_unexpected_out");
        else begin
          e = aq.pop_front();
          check("a_result", {a_inv, a_sat, a_intout}, {e.r.inv, e.r.sat, e.r.val[15:0]});
          if (chk_lat) check("a_latency", cyc - e.cyc, 3);
        end
      end
      if (a_in_valid && a_in_ready) aq.push_back('{model(a_f, a_rm, 16), cyc});
      a_prev_stall = a_out_valid && !a_out_ready;
      a_hold = {a_inv, a_sat, a_intout};

      if (b_prev_stall)
        check("b_stall_hold", {b_out_valid, b_inv, b_sat, b_intout}, {1'b1, b_hold});
      if (b_out_valid && b_out_ready) begin
        b_outs++;
        if (bq.size() == 0) fail("b_unexpected_out");
        else begin
          e = bq.pop_front();
          check("b_result", {b_inv, b_sat, b_intout}, {e.r.inv, e.r.sat, e.r.val[7:0]});
          if (chk_lat) check("b_latency", cyc - e.cyc, 3);
        end
      end
      if (b_in_valid && b_in_ready) bq.push_back('{model(b_f, b_rm, 8), cyc});
      b_prev_stall = b_out_valid && !b_out_ready;
      b_hold = {b_inv, b_sat, b_intout};
    end
  end
  assign b_hold_unused = '0;

  task automatic a_send(input logic [31:0] f, input logic rm);
    bit ok;
    a_f = f;
    a_rm = rm;
    a_in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    fail("a_send");
  endtask

  task automatic b_send(input logic [31:0] f, input logic rm);
    bit ok;
    b_f = f;
    b_rm = rm;
    b_in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    fail("b_send");
  endtask

  task automatic idle(input int n);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hand-computed vectors pinning the model
  localparam int NP = 23;
  logic [31:0] pf [NP] = '{32'h00000000, 32'h80000000, 32'h3f000000, 32'h3fc00000, 32'hbf8ccccd,
                           32'h43b5abee, 32'hc4aa6afb, 32'h3fc00000, 32'h40200000, 32'h3f000000,
                           32'hbfc00000, 32'hbf333333, 32'hbf333333, 32'h489e616b, 32'hc7000000,
                           32'hc7000100, 32'h7f800000, 32'hff800000, 32'h7fc00000, 32'h42fe0000,
                           32'h43000000, 32'hc3000000, 32'h4f000000};
  logic        prm [NP] = '{0,0,0,0,0,0,0, 1,1,1,1,1,0, 0,0,0,0,0,0, 0,0,0,0};
  logic [17:0] pexp [NP] = '{18'h00000, 18'h00000, 18'h00000, 18'h00001, 18'h0ffff,
                             18'h0016b, 18'h0faad, 18'h00002, 18'h00002, 18'h00000,
                             18'h0fffe, 18'h0ffff, 18'h00000, 18'h17fff, 18'h08000,
                             18'h18000, 18'h17fff, 18'h18000, 18'h20000, 18'h0007f,
                             18'h1007f, 18'h00080, 18'h1007f};

  initial begin
    res_t r;
    int w, o0;
    for (int i = 0; i < NP; i++) begin
      w = (i >= 19) ? 8 : 16;
      r = model(pf[i], prm[i], w);
      check($sformatf("model_pin%0d", i),
            {r.inv, r.sat, (w == 8) ? {8'd0, r.val[7:0]} : r.val[15:0]}, pexp[i]);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_out", {a_out_valid, a_inv, a_sat, a_intout}, 0);
    check("reset_b_out", {b_out_valid, b_inv, b_sat, b_intout}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {a_in_ready, b_in_ready}, 2'b11);
    @(posedge clk);
    #1;

    // Directed vectors back-to-back, latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 19; i++) a_send(pf[i], prm[i]);
    for (int i = 19; i < NP; i++) b_send(pf[i], prm[i]);
    idle(8);
    check("directed_drain", {aq.size(), bq.size()}, 0);
    chk_lat = 1'b0;

    // Backpressure: 5 items, output held for 4 cycles after first out_valid
    o0 = a_outs;
    a_out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) a_send(32'h42000000 + (i << 20), i[0]);
        a_in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = a_out_valid;
        end
        if (!seen) fail("bp_out_valid");
        repeat (4) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_count", a_outs - o0, 5);
    check("bp_drain", aq.size(), 0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) a_send(32'h44000000 + (i << 16), 1'b0);
    a_in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    o0 = a_outs;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_out_valid", a_out_valid, 0);
    end
    @(posedge clk);
    #1;
    check("rst_no_stale", a_outs - o0, 0);
    chk_lat = 1'b1;
    a_send(32'h43b5abee, 1'b1);
    idle(6);
    check("rst_resume", a_outs - o0, 1);
    chk_lat = 1'b0;

    // Randomized traffic with random backpressure on both instances
    for (int n = 0; n < 3000; n++) begin
      a_in_valid  = ($urandom % 4) != 0;
      a_f         = rand_float();
      a_rm        = $urandom % 2;
      a_out_ready = ($urandom % 3) != 0;
      b_in_valid  = ($urandom % 4) != 0;
      b_f         = rand_float();
      b_rm        = $urandom % 2;
      b_out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    idle(10);
    check("rand_drain", {aq.size(), bq.size()}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
